// File: rtl/codec_init_seq.sv
// Power-up register loader for an I2C audio codec: walks a fixed six-entry
// (reg, data) table through a byte-write engine, with NACK retries, a timeout and bus gaps.
module codec_init_seq #(
  parameter logic [6:0]  DEV_ADDR       = 7'h18,
  parameter int unsigned MAX_RETRY      = 3,
  parameter int unsigned GAP_CYCLES     = 500,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       i2c_busy,
  input  logic       i2c_done,
  input  logic       i2c_nack,
  output logic       i2c_go,
  output logic [6:0] i2c_dev,
  output logic [7:0] i2c_reg,
  output logic [7:0] i2c_data,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [2:0] fail_idx
);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT_DONE, S_GAP, S_DONE, S_FAIL
  } state_e;

  localparam logic [2:0]  LAST_IDX    = 3'd5;
  localparam logic [1:0]  RETRY_MAX   = 2'(MAX_RETRY);
  localparam logic [15:0] GAP_LOAD    = 16'(GAP_CYCLES - 1);
  localparam logic [15:0] SETTLE_LOAD = 16'(16 * GAP_CYCLES - 1);
  localparam logic [15:0] TMO_LAST    = 16'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [1:0]  retry_q, retry_d;
  logic [15:0] gap_q, gap_d;
  logic [15:0] tmo_q, tmo_d;
  logic [2:0]  fail_idx_q, fail_idx_d;

  function automatic logic [15:0] table_entry(input logic [2:0] i);
    case (i)
      3'd0:    table_entry = {8'h00, 8'h80};
      3'd1:    table_entry = {8'h01, 8'h04};
      3'd2:    table_entry = {8'h02, 8'h01};
      3'd3:    table_entry = {8'h03, 8'h03};
      3'd4:    table_entry = {8'h04, 8'h03};
      3'd5:    table_entry = {8'h05, 8'h01};
      default: table_entry = {8'h00, 8'h80};
    endcase
  endfunction

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      retry_q    <= '0;
      gap_q      <= '0;
      tmo_q      <= '0;
      fail_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      retry_q    <= retry_d;
      gap_q      <= gap_d;
      tmo_q      <= tmo_d;
      fail_idx_q <= fail_idx_d;
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    retry_d    = retry_q;
    gap_d      = gap_q;
    tmo_d      = tmo_q;
    fail_idx_d = fail_idx_q;
    i2c_go     = 1'b0;

    case (state_q)
      S_IDLE, S_DONE, S_FAIL: begin
        if (start) begin
          state_d = S_ISSUE;
          idx_d   = '0;
          retry_d = '0;
          gap_d   = '0;
          tmo_d   = '0;
        end
      end
      S_ISSUE: begin
        if (!i2c_busy) begin
          i2c_go  = 1'b1;
          tmo_d   = '0;
          state_d = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        // A completion on the final timeout cycle still counts.
        if (i2c_done) begin
          if (!i2c_nack) begin
            retry_d = '0;
            if (idx_q == LAST_IDX) begin
              state_d = S_DONE;
            end else begin
              idx_d   = idx_q + 3'd1;
              gap_d   = (idx_q == 3'd0) ? SETTLE_LOAD : GAP_LOAD;
              state_d = S_GAP;
            end
          end else if (retry_q < RETRY_MAX) begin
            retry_d = retry_q + 2'd1;
            gap_d   = GAP_LOAD;
            state_d = S_GAP;
          end else begin
            fail_idx_d = idx_q;
            state_d    = S_FAIL;
          end
        end else if (tmo_q == TMO_LAST) begin
          fail_idx_d = idx_q;
          state_d    = S_FAIL;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      S_GAP: begin
        if (gap_q == '0) state_d = S_ISSUE;
        else             gap_d   = gap_q - 16'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy                = (state_q == S_ISSUE) || (state_q == S_WAIT_DONE) || (state_q == S_GAP);
  assign done                = (state_q == S_DONE);
  assign error               = (state_q == S_FAIL);
  assign fail_idx            = fail_idx_q;
  assign i2c_dev             = DEV_ADDR;
  assign {i2c_reg, i2c_data} = table_entry(idx_q);

endmodule

// File: doc/codec_init_seq.md
CODEC_INIT_SEQ -- requirements
Module: codec_init_seq

Interface
REQ-001 Parameter DEV_ADDR, default 7'h18, codec I2C 7-bit slave address driven on i2c_dev.
REQ-002 Parameter MAX_RETRY, default 3, NACK retries allowed per table entry (range 0..3).
REQ-003 Parameter GAP_CYCLES, default 500, idle clk cycles between transactions (one 100 kHz bit at 50 MHz).
REQ-004 Parameter TIMEOUT_CYCLES, default 50000, max clk cycles waiting for i2c_done (16-bit counter).
REQ-005 clk  input  1  system clock, 50 MHz.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 start  input  1  single-cycle request to run the init table.
REQ-008 i2c_busy  input  1  byte-write engine busy; high blocks issue.
REQ-009 i2c_done  input  1  one-cycle pulse: engine finished a transaction.
REQ-010 i2c_nack  input  1  qualifier valid only with i2c_done; 1 = slave NACKed.
REQ-011 i2c_go  output  1  one-cycle pulse launching a 3-byte write (dev, reg, data).
REQ-012 i2c_dev  output  7  slave address, constant DEV_ADDR.
REQ-013 i2c_reg  output  8  register address of current entry.
REQ-014 i2c_data  output  8  data byte of current entry.
REQ-015 busy  output  1  high from accepted start until DONE or FAIL.
REQ-016 done  output  1  level, table completed; cleared by next start or reset.
REQ-017 error  output  1  level, sequence aborted; cleared by next start or reset.
REQ-018 fail_idx  output  3  table index of the failing entry; valid while error=1.

Function
REQ-019 Fixed table, index 0..5 (reg, data): 0 (0x00,0x80) soft reset; 1 (0x01,0x04) slave mode; 2 (0x02,0x01) ADC clk div2; 3 (0x03,0x03) select ADC; 4 (0x04,0x03) select IADC; 5 (0x05,0x01) enable ADC.
REQ-020 States: IDLE, ISSUE, WAIT_DONE, GAP, DONE, FAIL; 3-bit idx, 2-bit retry, 16-bit gap counter, 16-bit timeout counter.
REQ-021 IDLE/DONE/FAIL + start=1 -> ISSUE next cycle; idx=0, retry=0, done=0, error=0, busy=1.
REQ-022 start while busy=1 ignored, no effect on any state or counter.
REQ-023 ISSUE: when i2c_busy=0, assert i2c_go for exactly one cycle, -> WAIT_DONE; while i2c_busy=1 stay in ISSUE, i2c_go=0.
REQ-024 i2c_reg/i2c_data reflect table[idx] and SHALL stay stable from ISSUE entry until WAIT_DONE exit.
REQ-025 WAIT_DONE, i2c_done=1, i2c_nack=0: retry=0; idx=5 -> DONE (done=1, busy=0); else idx+1, -> GAP.
REQ-026 WAIT_DONE, i2c_done=1, i2c_nack=1: retry<MAX_RETRY -> retry+1, idx unchanged, -> GAP; else -> FAIL.
REQ-027 WAIT_DONE timeout counter starts at 0 on entry; i2c_done absent on the cycle count reaches TIMEOUT_CYCLES-1 -> FAIL; i2c_done on that cycle takes priority.
REQ-028 GAP waits GAP_CYCLES cycles, then -> ISSUE; after successful entry 0 wait 16*GAP_CYCLES (codec soft-reset settle).
REQ-029 FAIL: error=1, busy=0, fail_idx=idx latched on entry; holds until start or reset.
REQ-030 i2c_done/i2c_nack outside WAIT_DONE ignored.
REQ-031 No idx wrap: idx never exceeds 5.

Reset
REQ-032 reset=0 asynchronously forces IDLE; i2c_go, busy, done, error=0; fail_idx, idx, retry, counters=0; i2c_reg/i2c_data=table[0].
REQ-033 Reset mid-transaction aborts without further i2c_go; the engine is reset by the same net.
REQ-034 After reset release, block stays IDLE until start.

Verification
REQ-035 start, engine ACKs all -> six i2c_go pulses, reg 0x00..0x05 with data 0x80,0x04,0x01,0x03,0x03,0x01; done=1, error=0.
REQ-036 NACK on idx 2 twice then ACK -> idx 2 issued 3 times, sequence completes, done=1.
REQ-037 NACK on idx 3 four times (MAX_RETRY=3) -> 4 issues of idx 3, error=1, fail_idx=3, idx 4 never issued.
REQ-038 Never pulse i2c_done after idx 1 -> error=1, fail_idx=1 exactly TIMEOUT_CYCLES cycles after that i2c_go.
REQ-039 i2c_busy held high 100 cycles at ISSUE -> i2c_go delayed until first cycle i2c_busy=0; second start during run ignored.
REQ-040 reset pulsed during WAIT_DONE of idx 4 -> all outputs at reset values same cycle; new start re-runs from idx 0.
